ms_timeout_sched: RTL and testbench
===================================

// Module: ms_timeout_sched
// PURPOSE
//  Shared millisecond timebase plus N independent one-shot timeout channels for the
//  blackjack controller (dealer draw delay, result display hold, button lockout, ...).
//  Requesters arm a channel with a duration in ms; expiries are queued and handed to
//  the game FSM one at a time through a valid/ready event port, round-robin fair.
// PARAMETERS
//  CLK_HZ   50_000_000  input clock frequency; TICK_DIV = CLK_HZ/1000 cycles per ms
//  N_CH     4           number of timeout channels (2..16)
//  DUR_W    16          duration width in ms (max 65535 ms)
// PORTS
//  clk        in   1            system clock, single domain
//  rst        in   1            synchronous, active-high reset
//  arm        in   N_CH         per-channel start pulse (1 cycle)
//  arm_dur    in   N_CH*DUR_W   duration of ch i in bits [i*DUR_W +: DUR_W], sampled with arm[i]
//  cancel     in   N_CH         per-channel abort pulse
//  busy       out  N_CH         ch i running or expired-not-yet-consumed
//  evt_valid  out  1            an expired channel is presented
//  evt_id     out  $clog2(N_CH) index of presented channel
//  evt_ready  in   1            consumer accepts event when evt_valid & evt_ready
//  now_ms     out  32           free-running ms since reset, wraps 2^32-1 -> 0
//  tick_ms    out  1            1-cycle pulse each ms boundary
// BEHAVIOUR
//  Reset: prescaler=0, now_ms=0, tick_ms=0, all channels IDLE, busy=0, evt_valid=0,
//   evt_id=0, round-robin pointer=0. All outputs registered.
//  Timebase: prescaler counts 0..TICK_DIV-1; cycle where it equals TICK_DIV-1 it wraps
//   to 0 and tick_ms=1 on the next cycle together with now_ms+1.
//  Channel states: IDLE -> RUN (arm) -> PEND (expiry) -> IDLE (event accepted).
//   arm[i]: remaining<=arm_dur, state RUN; if arm_dur==0, state PEND directly.
//   arm in RUN restarts with new duration; arm in PEND drops the pending event, restarts.
//   cancel[i]: state IDLE from any state, remaining cleared. arm & cancel same cycle: arm wins.
//   On tick_ms: each RUN channel with remaining==1 -> PEND, else remaining-1.
//   Resolution: expiry occurs between dur-1 and dur ms after arm (first ms partial).
//  Event port: when evt_valid=0 and any PEND, next cycle evt_valid=1, evt_id = first PEND
//   channel at or after pointer (cyclic). evt_id stable while evt_valid & !evt_ready.
//   Handshake: that channel -> IDLE, pointer <= evt_id+1 (mod N_CH), evt_valid=0 next
//   cycle; next PEND channel presented the following cycle (1 bubble per event).
//   Withdrawal: arm or cancel of the presented channel drops evt_valid next cycle,
//   the only case evt_valid falls without handshake; handshake in that same cycle is void.
//  busy[i] = (state!=IDLE), registered with state.
//  Widths: remaining DUR_W bits, no underflow (decrement only when >=2); now_ms wraps silently.
//  Reset mid-operation: all timers and pending events discarded, no event emitted.
// STRUCTURE
//  timer_pkg.vh: state codes ST_IDLE/ST_RUN/ST_PEND, MS_PER_S, default CLK_HZ.
//  Sub-module ms_tick_gen (clk, rst -> tick_ms, now_ms): prescaler + ms counter, reusable
//   by other blocks needing a timebase. Channel array + RR picker inline in ms_timeout_sched.
// TESTING (sim with CLK_HZ=4000 -> TICK_DIV=4)
//  Reset then idle 40 cycles -> tick_ms every 4th cycle, now_ms=10, evt_valid=0.
//  arm ch1 dur=3, evt_ready=1 -> busy[1]=1, evt_valid with evt_id=1 after 3rd tick; busy[1]=0
//   after handshake; exactly one event.
//  arm ch0..3 dur=2 same cycle, evt_ready=0 until all PEND then held 1 -> ids 0,1,2,3 in order,
//   one bubble between; repeat with pointer at 2 -> order 2,3,0,1.
//  arm ch2 dur=5, cancel ch2 after 2 ticks -> busy[2]=0, no event ever; arm+cancel same
//   cycle dur=1 -> event id 2 after 1 tick.
//  ch3 presented, evt_ready=0, re-arm ch3 dur=4 -> evt_valid=0 next cycle, event again after
//   4 ticks; arm dur=0 -> evt_valid within 2 cycles.
//  rst asserted while 2 channels PEND and 1 RUN -> all outputs reset values next cycle, no event.

Source files
------------

// File: rtl/ms_timeout_sched_pkg.sv
// Shared definitions for the millisecond timebase and the timeout channel array.
package ms_timeout_sched_pkg;

    localparam int MS_PER_S       = 1000;
    localparam int DEFAULT_CLK_HZ = 50_000_000;

    // Per-channel lifecycle: armed channels run, expire into PEND, and are
    // released back to IDLE when the consumer takes the event.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } ch_state_e;

    // Cyclic wrap for round-robin indices; v is always below 2*n here.
    function automatic int rr_wrap(input int v, input int n);
        return (v >= n) ? v - n : v;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond timebase: a prescaler that divides clk down to 1 kHz, a registered
// 1-cycle tick at each ms boundary, and a free-running ms counter.
module ms_tick_gen
    import ms_timeout_sched_pkg::*;
#(
    parameter int CLK_HZ = DEFAULT_CLK_HZ
) (
    input  logic        clk,
    input  logic        rst,
    output logic        tick_ms,
    output logic [31:0] now_ms
);

    localparam int TICK_DIV = CLK_HZ / MS_PER_S;
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PRE_W-1:0] presc_q, presc_d;
    logic             tick_q, tick_d;
    logic [31:0]      now_q, now_d;
    logic             wrap;

    // Prescaler wrap raises the tick and advances the ms count on the next edge.
    always_comb begin
        wrap    = (presc_q == PRE_W'(TICK_DIV - 1));
        presc_d = wrap ? '0 : presc_q + PRE_W'(1);
        tick_d  = wrap;
        now_d   = wrap ? now_q + 32'd1 : now_q;
    end

    // Timebase registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (rst) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            now_q   <= '0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            now_q   <= now_d;
        end
    end

    assign tick_ms = tick_q;
    assign now_ms  = now_q;

endmodule

// File: rtl/ms_timeout_sched.sv
// N one-shot ms timeout channels sharing one timebase. Expired channels are
// handed out one at a time on a valid/ready port, picked round-robin.
module ms_timeout_sched
    import ms_timeout_sched_pkg::*;
#(
    parameter int CLK_HZ = DEFAULT_CLK_HZ,
    parameter int N_CH   = 4,
    parameter int DUR_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         arm,
    input  logic [N_CH*DUR_W-1:0]   arm_dur,
    input  logic [N_CH-1:0]         cancel,
    output logic [N_CH-1:0]         busy,
    output logic                    evt_valid,
    output logic [$clog2(N_CH)-1:0] evt_id,
    input  logic                    evt_ready,
    output logic [31:0]             now_ms,
    output logic                    tick_ms
);

    localparam int ID_W = $clog2(N_CH);

    ch_state_e        state_q [N_CH];
    ch_state_e        state_d [N_CH];
    logic [DUR_W-1:0] rem_q   [N_CH];
    logic [DUR_W-1:0] rem_d   [N_CH];
    logic [N_CH-1:0]  busy_q, busy_d;
    logic             evt_valid_q, evt_valid_d;
    logic [ID_W-1:0]  evt_id_q, evt_id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             tick;
    logic             withdraw;
    logic             accept;
    logic             pick_found;
    logic [ID_W-1:0]  pick_id;
    logic [ID_W-1:0]  scan_idx;

    ms_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .tick_ms (tick),
        .now_ms  (now_ms)
    );

    // A re-arm or cancel of the presented channel withdraws it and voids any handshake.
    always_comb begin
        withdraw = evt_valid_q && (arm[evt_id_q] || cancel[evt_id_q]);
        accept   = evt_valid_q && evt_ready && !withdraw;
    end

    // Per-channel next state: arm beats cancel beats handshake beats ms tick.
    always_comb begin
        // NOTE: every variable gets its hold value before the priority chain, so
        // no path leaves a signal unassigned and no latch is inferred.
        busy_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            rem_d[i]   = rem_q[i];
            if (arm[i]) begin
                rem_d[i]   = arm_dur[i*DUR_W +: DUR_W];
                state_d[i] = (arm_dur[i*DUR_W +: DUR_W] == '0) ? ST_PEND : ST_RUN;
            end else if (cancel[i]) begin
                state_d[i] = ST_IDLE;
                rem_d[i]   = '0;
            end else if (accept && (evt_id_q == ID_W'(i))) begin
                state_d[i] = ST_IDLE;
            end else if (tick && (state_q[i] == ST_RUN)) begin
                if (rem_q[i] >= DUR_W'(2)) begin
                    rem_d[i] = rem_q[i] - DUR_W'(1);
                end else begin
                    state_d[i] = ST_PEND;
                end
            end
            busy_d[i] = (state_d[i] != ST_IDLE);
        end
    end

    // Event port: present the first pending channel at or after the pointer,
    // hold it until taken or withdrawn, then leave one idle cycle.
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        ptr_d       = ptr_q;
        pick_found  = 1'b0;
        pick_id     = '0;
        scan_idx    = '0;
        for (int k = 0; k < N_CH; k++) begin
            scan_idx = ID_W'(rr_wrap(32'(ptr_q) + k, N_CH));
            if (!pick_found && (state_q[scan_idx] == ST_PEND) &&
                !arm[scan_idx] && !cancel[scan_idx]) begin
                pick_found = 1'b1;
                pick_id    = scan_idx;
            end
        end
        if (evt_valid_q) begin
            if (withdraw || accept) begin
                evt_valid_d = 1'b0;
            end
            if (accept) begin
                ptr_d = ID_W'(rr_wrap(32'(evt_id_q) + 1, N_CH));
            end
        end else if (pick_found) begin
            evt_valid_d = 1'b1;
            evt_id_d    = pick_id;
        end
    end

    // Channel array, busy flags and event port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the channel arrays are reset element by element because a
            // stale RUN/PEND entry after reset would fire a phantom event.
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_IDLE;
                rem_q[i]   <= '0;
            end
            busy_q      <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                rem_q[i]   <= rem_d[i];
            end
            busy_q      <= busy_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            ptr_q       <= ptr_d;
        end
    end

    assign busy      = busy_q;
    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign tick_ms   = tick;

endmodule

// File: tb/tb_ms_timeout_sched.sv
// Self-checking bench for ms_timeout_sched with a 4-cycle ms (CLK_HZ=4000).
// Expected event ids go into a queue when channels are armed; a negedge
// monitor pops and compares them on every accepted handshake.
module tb_ms_timeout_sched;

    localparam int CLK_HZ = 4000;
    localparam int N_CH   = 4;
    localparam int DUR_W  = 16;
    localparam int ID_W   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_CH-1:0]       arm;
    logic [N_CH*DUR_W-1:0] arm_dur;
    logic [N_CH-1:0]       cancel;
    logic [N_CH-1:0]       busy;
    logic                  evt_valid;
    logic [ID_W-1:0]       evt_id;
    logic                  evt_ready;
    logic [31:0]           now_ms;
    logic                  tick_ms;

    int n_checks = 0;
    int n_errors = 0;
    int n_evt    = 0;
    int exp_q[$];

    logic            hold_prev = 1'b0;
    logic [ID_W-1:0] id_prev   = '0;

    ms_timeout_sched #(
        .CLK_HZ (CLK_HZ),
        .N_CH   (N_CH),
        .DUR_W  (DUR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .arm_dur   (arm_dur),
        .cancel    (cancel),
        .busy      (busy),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_ready (evt_ready),
        .now_ms    (now_ms),
        .tick_ms   (tick_ms)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_arm(input int ch, input int dur);
        arm[ch] = 1'b1;
        arm_dur[ch*DUR_W +: DUR_W] = DUR_W'(dur);
    endtask

    task automatic clear_pulses();
        arm    = '0;
        cancel = '0;
    endtask

    // Called right after the arm edge; counts ms ticks the channel will consume
    // until evt_valid rises, bounded by budget cycles.
    task automatic wait_valid(input int budget, output int ticks);
        int n;
        n     = 0;
        ticks = tick_ms ? 1 : 0;
        while (!evt_valid && n < budget) begin
            cyc();
            n++;
            if (tick_ms) ticks++;
        end
    endtask

    // One channel armed alone with evt_ready=1; checks latency in ticks and release.
    task automatic single_evt(input int ch, input int dur, input int exp_ticks,
                              input bit with_cancel, input string tag);
        int t;
        evt_ready = 1'b1;
        exp_q.push_back(ch);
        set_arm(ch, dur);
        if (with_cancel) cancel[ch] = 1'b1;
        cyc();
        clear_pulses();
        check({tag, "_busy_on"}, busy[ch], 1);
        wait_valid(60, t);
        check({tag, "_valid"}, evt_valid, 1);
        check({tag, "_ticks"}, t, exp_ticks);
        check({tag, "_id"}, evt_id, ch);
        cyc();
        check({tag, "_valid_drop"}, evt_valid, 0);
        check({tag, "_busy_off"}, busy[ch], 0);
    endtask

    // All channels armed together with dur=2 while the consumer stalls, then
    // drained with evt_ready held high; first is the current pointer.
    task automatic run_batch(input int first, input string tag);
        int t;
        int hs;
        int last;
        evt_ready = 1'b0;
        for (int ch = 0; ch < N_CH; ch++) set_arm(ch, 2);
        cyc();
        clear_pulses();
        for (int k = 0; k < N_CH; k++) exp_q.push_back((first + k) % N_CH);
        wait_valid(60, t);
        check({tag, "_valid"}, evt_valid, 1);
        check({tag, "_ticks"}, t, 2);
        check({tag, "_first_id"}, evt_id, first);
        check({tag, "_busy_all"}, busy, 4'hF);
        evt_ready = 1'b1;
        hs   = 0;
        last = -1;
        for (int c = 0; c < 24 && hs < N_CH; c++) begin
            if (evt_valid) begin
                if (last >= 0) check({tag, "_bubble_gap"}, c - last, 2);
                last = c;
                hs++;
            end
            cyc();
        end
        check({tag, "_accepts"}, hs, N_CH);
        check({tag, "_busy_clear"}, busy, 0);
    endtask

    // Scoreboard monitor: compares every accepted event and checks evt_id
    // stays put while the consumer stalls.
    always @(negedge clk) begin
        if (rst) begin
            hold_prev <= 1'b0;
        end else begin
            if (hold_prev && evt_valid) check("evt_id_stable", evt_id, id_prev);
            if (evt_valid && evt_ready && !arm[evt_id] && !cancel[evt_id]) begin
                check("evt_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("evt_id_order", evt_id, exp_q.pop_front());
                n_evt <= n_evt + 1;
            end
            hold_prev <= evt_valid && !evt_ready && !arm[evt_id] && !cancel[evt_id];
            id_prev   <= evt_id;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int nt;
        int first_tick;
        int last_tick;
        int t;
        int n_valid;
        int evt_base;

        rst       = 1'b1;
        arm       = '0;
        arm_dur   = '0;
        cancel    = '0;
        evt_ready = 1'b0;
        repeat (3) cyc();
        check("rst_now_ms", now_ms, 0);
        check("rst_tick", tick_ms, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", evt_valid, 0);
        check("rst_id", evt_id, 0);
        rst = 1'b0;

        // Idle timebase: ticks on every 4th edge, 10 ms after 40 cycles.
        nt = 0;
        first_tick = -1;
        last_tick  = -1;
        for (int c = 1; c <= 40; c++) begin
            cyc();
            if (tick_ms) begin
                if (nt == 0) first_tick = c;
                else check("tick_gap", c - last_tick, 4);
                last_tick = c;
                nt++;
            end
        end
        check("tick_first", first_tick, 4);
        check("tick_count", nt, 10);
        check("now_ms_40", now_ms, 10);
        check("idle_valid", evt_valid, 0);

        // Single 3 ms timeout on ch1, exactly one event; pointer moves to 2.
        evt_base = n_evt;
        single_evt(1, 3, 3, 1'b0, "ch1");
        repeat (20) cyc();
        check("ch1_one_event", n_evt - evt_base, 1);

        // Pointer is 2, so the batch drains 2,3,0,1; pointer returns to 2.
        run_batch(2, "batch_p2");
        // An event on ch3 moves the pointer to 0; the next batch drains 0,1,2,3.
        single_evt(3, 1, 1, 1'b0, "ch3");
        run_batch(0, "batch_p0");

        // Cancel ch2 mid-run: never expires.
        evt_ready = 1'b1;
        set_arm(2, 5);
        cyc();
        clear_pulses();
        t = tick_ms ? 1 : 0;
        for (int n = 0; n < 40 && t < 2; n++) begin
            cyc();
            if (tick_ms) t++;
        end
        cancel[2] = 1'b1;
        cyc();
        clear_pulses();
        check("cancel_busy", busy[2], 0);
        n_valid = 0;
        repeat (40) begin
            cyc();
            if (evt_valid) n_valid++;
        end
        check("cancel_no_evt", n_valid, 0);

        // Arm and cancel together: arm wins, 1 ms later ch2 fires; pointer -> 3.
        single_evt(2, 1, 1, 1'b1, "armcancel");

        // Withdrawal of presented ch3 by re-arm, then by zero-duration re-arm.
        evt_ready = 1'b0;
        exp_q.push_back(3);
        set_arm(3, 1);
        cyc();
        clear_pulses();
        wait_valid(60, t);
        check("wd_present", evt_valid, 1);
        check("wd_id", evt_id, 3);
        set_arm(3, 4);
        cyc();
        clear_pulses();
        check("wd_drop", evt_valid, 0);
        check("wd_busy", busy[3], 1);
        wait_valid(60, t);
        check("wd_rearm_valid", evt_valid, 1);
        check("wd_rearm_ticks", t, 4);
        check("wd_rearm_id", evt_id, 3);
        set_arm(3, 0);
        cyc();
        clear_pulses();
        check("dur0_drop", evt_valid, 0);
        check("dur0_busy", busy[3], 1);
        cyc();
        check("dur0_valid", evt_valid, 1);
        check("dur0_id", evt_id, 3);
        evt_ready = 1'b1;
        cyc();
        check("dur0_taken", evt_valid, 0);
        check("dur0_idle", busy[3], 0);

        // Reset with ch0/ch1 pending and ch2 running: everything discarded.
        evt_ready = 1'b0;
        set_arm(0, 1);
        set_arm(1, 1);
        set_arm(2, 20);
        cyc();
        clear_pulses();
        wait_valid(60, t);
        check("pre_rst_valid", evt_valid, 1);
        check("pre_rst_id", evt_id, 0);
        check("pre_rst_busy", busy, 4'b0111);
        rst = 1'b1;
        cyc();
        check("mid_rst_now_ms", now_ms, 0);
        check("mid_rst_tick", tick_ms, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", evt_valid, 0);
        check("mid_rst_id", evt_id, 0);
        rst = 1'b0;
        evt_ready = 1'b1;
        n_valid = 0;
        repeat (120) begin
            cyc();
            if (evt_valid) n_valid++;
        end
        check("post_rst_no_evt", n_valid, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        check("total_events", n_evt, 12);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
